// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack clock-domain-crossing handshake.
// A word is captured on accept and held on data_out while req_out walks the
// destination through raise-req / see-ack / drop-req / see-ack-drop.
module cdc_handshake_tx #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  src_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  ack_async,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done
);

  // Reject synchronizer depths outside the supported range at elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("cdc_handshake_tx: SYNC_STAGES must be in 2..4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_chain;
  logic                   ack_sync;
  logic                   accept;

  // Synchronizer for the destination acknowledge; only the last stage is used.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      ack_chain <= '0;
    end else begin
      ack_chain <= {ack_chain[SYNC_STAGES-2:0], ack_async};
    end
  end

  assign ack_sync = ack_chain[SYNC_STAGES-1];

  // A stale ack still high from a previous transfer blocks a new accept.
  assign in_ready = (state == ST_IDLE) && !ack_sync;
  assign accept   = in_valid && in_ready;

  // Handshake FSM; req_out, data_out, busy and done are all flops.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_out <= in_data;
            req_out  <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_sync) begin
            req_out <= 1'b0;
            state   <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (!ack_sync) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          req_out <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: directed scenarios with literal
// expectations plus a transaction-level model compared on every cycle.
`timescale 1ns/1ps
module tb_cdc_handshake_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;

  logic          src_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          ack_async = 1'b0;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int req_rise_cnt = 0;

  cdc_handshake_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .src_clk   (src_clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ack_async (ack_async),
    .req_out   (req_out),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done)
  );

  always #10 src_clk = ~src_clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: the block sees ack_async SS edges late; a transfer
  // is idle -> request raised -> request dropped -> complete.
  bit          m_busy = 1'b0;
  bit          m_req  = 1'b0;
  bit          m_done = 1'b0;
  logic [DW-1:0] m_data = '0;
  bit          ack_seen [SS];
  logic        prev_req = 1'b0;

  always @(posedge src_clk) begin : monitor
    bit          s_rst, s_valid, s_ack, seen;
    logic [DW-1:0] s_data;
    s_rst   = rst;
    s_valid = in_valid;
    s_ack   = ack_async;
    s_data  = in_data;
    seen    = ack_seen[SS-1];
    if (s_rst) begin
      m_busy = 1'b0;
      m_req  = 1'b0;
      m_done = 1'b0;
      m_data = '0;
      for (int i = 0; i < SS; i++) ack_seen[i] = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (s_valid && !seen) begin
          m_busy = 1'b1;
          m_req  = 1'b1;
          m_data = s_data;
        end
      end else if (m_req) begin
        if (seen) m_req = 1'b0;
      end else if (!seen) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
      for (int i = SS - 1; i > 0; i--) ack_seen[i] = ack_seen[i-1];
      ack_seen[0] = s_ack;
    end
    #1;
    check("model_req_out", 32'(req_out), 32'(m_req));
    check("model_data_out", 32'(data_out), 32'(m_data));
    check("model_busy", 32'(busy), 32'(m_busy));
    check("model_done", 32'(done), 32'(m_done));
    check("model_in_ready", 32'(in_ready), 32'(!m_busy && !ack_seen[SS-1]));
    if (done === 1'b1) done_cnt++;
    if (req_out === 1'b1 && prev_req !== 1'b1) req_rise_cnt++;
    prev_req = req_out;
  end

  task automatic step();
    @(posedge src_clk);
    #2;
  endtask

  task automatic wait_req(input logic v, input string name);
    for (int i = 0; i < 12 && req_out !== v; i++) step();
    check(name, 32'(req_out), 32'(v));
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 12 && done !== 1'b1; i++) step();
    check(name, 32'(done), 32'd1);
  endtask

  // Drive the destination side through a full ack cycle for the current request.
  task automatic finish_handshake();
    ack_async = 1'b1;
    wait_req(1'b0, "finish_req_drop");
    ack_async = 1'b0;
    wait_done("finish_done");
    step();
  endtask

  initial begin
    int ofs;
    // Reset
    rst = 1'b1;
    step();
    step();
    check("reset_req_out", 32'(req_out), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Basic transfer of 8'hA5
    in_data  = 8'hA5;
    in_valid = 1'b1;
    step();
    check("basic_req_after_accept", 32'(req_out), 32'd1);
    check("basic_data_after_accept", 32'(data_out), 32'hA5);
    check("basic_busy_after_accept", 32'(busy), 32'd1);
    in_valid  = 1'b0;
    in_data   = 8'h00;
    ack_async = 1'b1;
    step();
    check("basic_req_j", 32'(req_out), 32'd1);
    step();
    check("basic_req_j1", 32'(req_out), 32'd1);
    step();
    check("basic_req_j2", 32'(req_out), 32'd0);
    check("basic_data_held", 32'(data_out), 32'hA5);
    ack_async = 1'b0;
    step();
    check("basic_done_m", 32'(done), 32'd0);
    step();
    check("basic_done_m1", 32'(done), 32'd0);
    check("basic_busy_m1", 32'(busy), 32'd1);
    step();
    check("basic_done_m2", 32'(done), 32'd1);
    check("basic_busy_m2", 32'(busy), 32'd0);
    check("basic_ready_m2", 32'(in_ready), 32'd1);
    step();
    check("basic_done_single", 32'(done), 32'd0);
    check("basic_ready_after", 32'(in_ready), 32'd1);

    // Back-to-back with in_valid held high
    in_data  = 8'h01;
    in_valid = 1'b1;
    step();
    check("b2b_first_data", 32'(data_out), 32'h01);
    in_data   = 8'h02;
    ack_async = 1'b1;
    repeat (3) step();
    check("b2b_first_req_drop", 32'(req_out), 32'd0);
    check("b2b_first_data_held", 32'(data_out), 32'h01);
    ack_async = 1'b0;
    repeat (3) step();
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_data_at_done", 32'(data_out), 32'h01);
    check("b2b_req_at_done", 32'(req_out), 32'd0);
    step();
    check("b2b_second_req", 32'(req_out), 32'd1);
    check("b2b_second_data", 32'(data_out), 32'h02);
    in_valid = 1'b0;
    finish_handshake();

    // Stale ack present at reset release
    rst       = 1'b1;
    ack_async = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    check("stale_ready_low", 32'(in_ready), 32'd0);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    repeat (3) step();
    check("stale_no_req", 32'(req_out), 32'd0);
    check("stale_not_busy", 32'(busy), 32'd0);
    ack_async = 1'b0;
    step();
    check("stale_req_a", 32'(req_out), 32'd0);
    step();
    check("stale_req_a1", 32'(req_out), 32'd0);
    check("stale_ready_a1", 32'(in_ready), 32'd1);
    step();
    check("stale_req_a2", 32'(req_out), 32'd1);
    check("stale_data_a2", 32'(data_out), 32'h5A);
    in_valid = 1'b0;
    finish_handshake();

    // Reset while request is outstanding
    in_data  = 8'hC3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("rstreq_req_before", 32'(req_out), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstreq_req", 32'(req_out), 32'd0);
    check("rstreq_data", 32'(data_out), 32'd0);
    check("rstreq_busy", 32'(busy), 32'd0);
    check("rstreq_done", 32'(done), 32'd0);
    step();
    check("rstreq_no_done_after", 32'(done), 32'd0);
    check("rstreq_ready", 32'(in_ready), 32'd1);

    // Randomized ack timing over 20 transfers
    done_cnt     = 0;
    req_rise_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      in_data  = DW'($urandom);
      in_valid = 1'b1;
      wait_req(1'b1, "rand_accept");
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      @(posedge src_clk);
      ofs = int'($urandom_range(3, 15));
      #(ofs);
      ack_async = 1'b1;
      wait_req(1'b0, "rand_req_drop");
      repeat ($urandom_range(0, 3)) step();
      @(posedge src_clk);
      ofs = int'($urandom_range(3, 15));
      #(ofs);
      ack_async = 1'b0;
      wait_done("rand_done");
    end
    step();
    check("rand_done_count", 32'(done_cnt), 32'd20);
    check("rand_transfer_count", 32'(req_rise_cnt), 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of transferred word.
REQ-002 Parameter: SYNC_STAGES, default 2, depth of ack synchronizer chain (legal 2..4).
REQ-003 Port: src_clk  input  1  source-domain clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_data  input  DATA_WIDTH  word to send.
REQ-006 Port: in_valid  input  1  in_data valid this cycle.
REQ-007 Port: in_ready  output  1  block can accept a word this cycle.
REQ-008 Port: ack_async  input  1  acknowledge from destination domain, asynchronous to src_clk.
REQ-009 Port: req_out  output  1  request to destination domain, registered, glitch-free.
REQ-010 Port: data_out  output  DATA_WIDTH  held word to destination domain, registered.
REQ-011 Port: busy  output  1  handshake in progress (state != IDLE).
REQ-012 Port: done  output  1  single-cycle pulse on handshake completion.

Function
REQ-013 ack_async SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (ack_sync) SHALL be used by logic.
REQ-014 Four-phase protocol; FSM states IDLE, REQ, DROP.
REQ-015 in_ready SHALL be combinational: (state == IDLE) && !ack_sync.
REQ-016 Accept: at an edge with in_valid && in_ready, data_out <= in_data, req_out <= 1, state -> REQ.
REQ-017 REQ: hold req_out = 1 and data_out; at first edge with ack_sync == 1, req_out <= 0, state -> DROP.
REQ-018 DROP: hold req_out = 0 and data_out; at first edge with ack_sync == 0, state -> IDLE, done <= 1 for exactly that one cycle.
REQ-019 data_out SHALL change only on an accept edge; stable from accept through return to IDLE.
REQ-020 req_out SHALL change only on accept, REQ->DROP, or reset edges; no combinational path to req_out or data_out.
REQ-021 in_valid while not in_ready: ignored; no capture, no state change.
REQ-022 ack_sync high in IDLE (stale ack): in_ready = 0, no accept until ack_sync low.
REQ-023 ack_sync dropping in REQ before rising: no effect; remain in REQ.
REQ-024 Accept is one-cycle; next accept no earlier than the cycle after done.
REQ-025 busy = 1 in REQ and DROP, 0 in IDLE.

Reset
REQ-026 While rst = 1 at an edge: state -> IDLE; req_out, done, data_out, all sync stages -> 0.
REQ-027 Reset mid-handshake (REQ or DROP) SHALL abort without a done pulse; req_out low the cycle after the reset edge.
REQ-028 After rst deasserts, in_ready = 1 the first cycle provided ack_sync = 0.

Verification
REQ-029 Basic (SYNC_STAGES=2): in_data=8'hA5, in_valid=1 accepted edge k -> req_out=1, data_out=8'hA5, busy=1 after k; ack_async raised before edge j -> req_out=0 after edge j+2; ack_async lowered before edge m -> done=1 for the cycle after edge m+2, in_ready=1 thereafter.
REQ-030 Back-to-back: in_valid held high with 8'h01 then 8'h02 -> exactly two handshakes, data_out=8'h01 held until its done, second accept on the edge after done, never both.
REQ-031 Stale ack: ack_async=1 at reset release, in_valid=1 -> in_ready=0, no req_out until 2 edges after ack_async falls.
REQ-032 Reset in REQ: rst=1 one edge while req_out=1 -> req_out=0, data_out=0, busy=0, no done pulse.
REQ-033 Stability: randomized ack_async timing (3-15 ns offsets) over 20 transfers -> data_out never changes while busy=1, req_out toggles only per REQ-020, transfer count equals done count.
